// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sink: coordinate recovery, timing measurement, mode lock and probe capture
// Pipeline: two input flops (s1/s2), one state stage, one output register stage.
module vga_sync_receiver #(
  parameter int EXP_ACTIVE_W = 640,
  parameter int EXP_ACTIVE_H = 480,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [23:0] iRGB,
  input  logic [9:0]  iProbeX,
  input  logic [9:0]  iProbeY,
  output logic        oPixelValid,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [23:0] oRGB,
  output logic        oFrameStart,
  output logic [10:0] oLineLen,
  output logic [10:0] oActiveW,
  output logic [9:0]  oActiveH,
  output logic [10:0] oFrameLines,
  output logic        oLocked,
  output logic [7:0]  oErrCount,
  output logic [23:0] oProbeRGB,
  output logic        oProbeValid
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [10:0]   EXP_W   = 11'(EXP_ACTIVE_W);
  localparam logic [9:0]    EXP_H   = 10'(EXP_ACTIVE_H);
  localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

  logic        hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic        bl_s1_q, bl_s1_d, bl_s2_q, bl_s2_d;
  logic [23:0] rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d;

  logic [10:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
  logic        hs_seen_q, hs_seen_d;
  logic [10:0] x_q, x_d, active_w_q, active_w_d;
  logic        frame_bad_q, frame_bad_d;
  logic [9:0]  y_q, y_d, active_lines_q, active_lines_d, active_h_q, active_h_d;
  logic        first_line_q, first_line_d;
  logic [10:0] line_cnt_q, line_cnt_d, frame_lines_q, frame_lines_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [9:0]  probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [23:0] probe_rgb_q, probe_rgb_d;
  logic        probe_hit_q, probe_hit_d, frame_start_q, frame_start_d;

  logic        o_valid_q, o_valid_d, o_frame_start_q, o_frame_start_d;
  logic [9:0]  o_x_q, o_x_d, o_y_q, o_y_d, o_active_h_q, o_active_h_d;
  logic [23:0] o_rgb_q, o_rgb_d, o_probe_rgb_q, o_probe_rgb_d;
  logic [10:0] o_line_len_q, o_line_len_d, o_active_w_q, o_active_w_d;
  logic [10:0] o_frame_lines_q, o_frame_lines_d;
  logic        o_locked_q, o_locked_d, o_probe_valid_q, o_probe_valid_d;
  logic [7:0]  o_err_cnt_q, o_err_cnt_d;

  logic        hs_fall, vs_fall, bl_rise, bl_fall;
  logic        width_err, frame_good, timeout;
  logic [10:0] hcnt_inc, x_inc, x_cur;
  logic [9:0]  y_inc, y_cur;

  always_comb begin
    hs_s1_d  = iHS;
    hs_s2_d  = hs_s1_q;
    vs_s1_d  = iVS;
    vs_s2_d  = vs_s1_q;
    bl_s1_d  = iBLANK_n;
    bl_s2_d  = bl_s1_q;
    rgb_s1_d = iRGB;
    rgb_s2_d = rgb_s1_q;

    hs_fall = hs_s2_q & ~hs_s1_q;
    vs_fall = vs_s2_q & ~vs_s1_q;
    bl_rise = bl_s1_q & ~bl_s2_q;
    bl_fall = ~bl_s1_q & bl_s2_q;

    // Horizontal timing; the first HS fall after reset has no valid preceding line.
    hcnt_inc   = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    hcnt_d     = hs_fall ? 11'd0 : hcnt_inc;
    hs_seen_d  = hs_seen_q | hs_fall;
    line_len_d = (hs_fall && hs_seen_q) ? hcnt_inc : line_len_q;

    x_inc = (x_q == 11'h7FF) ? x_q : x_q + 11'd1;
    x_cur = x_q;
    if (bl_rise) begin
      x_cur = 11'd0;
    end else if (bl_s1_q) begin
      x_cur = x_inc;
    end
    x_d        = x_cur;
    width_err  = bl_fall && (x_inc != EXP_W);
    active_w_d = bl_fall ? x_inc : active_w_q;

    y_inc = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
    y_cur = y_q;
    if (bl_rise) begin
      y_cur = (first_line_q | vs_fall) ? 10'd0 : y_inc;
    end
    y_d          = y_cur;
    first_line_d = (first_line_q | vs_fall) & ~bl_rise;

    // Events coinciding with VS fall belong to the new frame.
    active_lines_d = vs_fall ? 10'd0 : active_lines_q;
    if (bl_rise && active_lines_d != 10'h3FF) begin
      active_lines_d = active_lines_d + 10'd1;
    end
    line_cnt_d = vs_fall ? 11'd0 : line_cnt_q;
    if (hs_fall && line_cnt_d != 11'h7FF) begin
      line_cnt_d = line_cnt_d + 11'd1;
    end
    frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | width_err);
    frame_good  = !(frame_bad_q | width_err) && (active_lines_q == EXP_H);

    timeout  = !hs_fall && (to_cnt_q >= TO_LAST);
    to_cnt_d = hs_fall ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1));

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (timeout) begin
      state_d    = ST_SEARCH;
      good_cnt_d = 4'd0;
    end else if (vs_fall) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_TRACK;
          good_cnt_d = 4'd0;
        end
        ST_TRACK: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d >= LOCK_N) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            state_d    = ST_TRACK;
            good_cnt_d = 4'd0;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          good_cnt_d = 4'd0;
        end
      endcase
    end

    // A SEARCH exit closes a partial frame, so its measurements are discarded.
    active_h_d    = active_h_q;
    frame_lines_d = frame_lines_q;
    if (vs_fall && !timeout && state_q != ST_SEARCH) begin
      active_h_d    = active_lines_q;
      frame_lines_d = line_cnt_q;
    end
    frame_start_d = vs_fall;

    probe_x_d   = vs_fall ? iProbeX : probe_x_q;
    probe_y_d   = vs_fall ? iProbeY : probe_y_q;
    probe_hit_d = bl_s1_q && (x_cur == {1'b0, probe_x_q}) && (y_cur == probe_y_q);
    probe_rgb_d = probe_hit_d ? rgb_s1_q : probe_rgb_q;

    o_valid_d       = bl_s2_q;
    o_x_d           = x_q[9:0];
    o_y_d           = y_q;
    o_rgb_d         = rgb_s2_q;
    o_frame_start_d = frame_start_q;
    o_line_len_d    = line_len_q;
    o_active_w_d    = active_w_q;
    o_active_h_d    = active_h_q;
    o_frame_lines_d = frame_lines_q;
    o_locked_d      = (state_q == ST_LOCKED);
    o_err_cnt_d     = err_cnt_q;
    o_probe_rgb_d   = probe_rgb_q;
    o_probe_valid_d = probe_hit_q;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      hs_s1_q <= 1'b0;  hs_s2_q <= 1'b0;
      vs_s1_q <= 1'b0;  vs_s2_q <= 1'b0;
      bl_s1_q <= 1'b0;  bl_s2_q <= 1'b0;
      rgb_s1_q <= '0;   rgb_s2_q <= '0;
      hcnt_q <= '0;     hs_seen_q <= 1'b0;   line_len_q <= '0;
      x_q <= '0;        active_w_q <= '0;    frame_bad_q <= 1'b0;
      y_q <= '0;        first_line_q <= 1'b0;
      active_lines_q <= '0; line_cnt_q <= '0;
      active_h_q <= '0; frame_lines_q <= '0;
      state_q <= ST_SEARCH; good_cnt_q <= '0; err_cnt_q <= '0;
      to_cnt_q <= '0;
      probe_x_q <= '0;  probe_y_q <= '0;     probe_rgb_q <= '0;
      probe_hit_q <= 1'b0; frame_start_q <= 1'b0;
      o_valid_q <= 1'b0; o_x_q <= '0; o_y_q <= '0; o_rgb_q <= '0;
      o_frame_start_q <= 1'b0; o_line_len_q <= '0; o_active_w_q <= '0;
      o_active_h_q <= '0; o_frame_lines_q <= '0; o_locked_q <= 1'b0;
      o_err_cnt_q <= '0; o_probe_rgb_q <= '0; o_probe_valid_q <= 1'b0;
    end else begin
      hs_s1_q <= hs_s1_d;  hs_s2_q <= hs_s2_d;
      vs_s1_q <= vs_s1_d;  vs_s2_q <= vs_s2_d;
      bl_s1_q <= bl_s1_d;  bl_s2_q <= bl_s2_d;
      rgb_s1_q <= rgb_s1_d; rgb_s2_q <= rgb_s2_d;
      hcnt_q <= hcnt_d;    hs_seen_q <= hs_seen_d; line_len_q <= line_len_d;
      x_q <= x_d;          active_w_q <= active_w_d; frame_bad_q <= frame_bad_d;
      y_q <= y_d;          first_line_q <= first_line_d;
      active_lines_q <= active_lines_d; line_cnt_q <= line_cnt_d;
      active_h_q <= active_h_d; frame_lines_q <= frame_lines_d;
      state_q <= state_d;  good_cnt_q <= good_cnt_d; err_cnt_q <= err_cnt_d;
      to_cnt_q <= to_cnt_d;
      probe_x_q <= probe_x_d; probe_y_q <= probe_y_d; probe_rgb_q <= probe_rgb_d;
      probe_hit_q <= probe_hit_d; frame_start_q <= frame_start_d;
      o_valid_q <= o_valid_d; o_x_q <= o_x_d; o_y_q <= o_y_d; o_rgb_q <= o_rgb_d;
      o_frame_start_q <= o_frame_start_d; o_line_len_q <= o_line_len_d;
      o_active_w_q <= o_active_w_d; o_active_h_q <= o_active_h_d;
      o_frame_lines_q <= o_frame_lines_d; o_locked_q <= o_locked_d;
      o_err_cnt_q <= o_err_cnt_d; o_probe_rgb_q <= o_probe_rgb_d;
      o_probe_valid_q <= o_probe_valid_d;
    end
  end

  assign oPixelValid = o_valid_q;
  assign oX          = o_x_q;
  assign oY          = o_y_q;
  assign oRGB        = o_rgb_q;
  assign oFrameStart = o_frame_start_q;
  assign oLineLen    = o_line_len_q;
  assign oActiveW    = o_active_w_q;
  assign oActiveH    = o_active_h_q;
  assign oFrameLines = o_frame_lines_q;
  assign oLocked     = o_locked_q;
  assign oErrCount   = o_err_cnt_q;
  assign oProbeRGB   = o_probe_rgb_q;
  assign oProbeValid = o_probe_valid_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a scaled 16x12 mode (24x16 totals)
module tb_vga_sync_receiver;

  localparam int AW = 16, AH = 12, LOCKF = 2, TO = 100;
  localparam int HT = 24, VT = 16, HS_BEG = 18, HS_END = 21, VS_BEG = 13, VS_END = 15;
  localparam int PX = 5, PY = 7;
  localparam logic [23:0] PROBE_RGB = 24'h123456;

  logic        clk = 1'b0;
  logic        iRST_n, iHS, iVS, iBLANK_n;
  logic [23:0] iRGB;
  logic [9:0]  iProbeX, iProbeY;
  logic        oPixelValid, oFrameStart, oLocked, oProbeValid;
  logic [9:0]  oX, oY, oActiveH;
  logic [23:0] oRGB, oProbeRGB;
  logic [10:0] oLineLen, oActiveW, oFrameLines;
  logic [7:0]  oErrCount;

  vga_sync_receiver #(
    .EXP_ACTIVE_W(AW), .EXP_ACTIVE_H(AH), .LOCK_FRAMES(LOCKF), .TIMEOUT(TO)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
    .iRGB(iRGB), .iProbeX(iProbeX), .iProbeY(iProbeY),
    .oPixelValid(oPixelValid), .oX(oX), .oY(oY), .oRGB(oRGB),
    .oFrameStart(oFrameStart), .oLineLen(oLineLen), .oActiveW(oActiveW),
    .oActiveH(oActiveH), .oFrameLines(oFrameLines), .oLocked(oLocked),
    .oErrCount(oErrCount), .oProbeRGB(oProbeRGB), .oProbeValid(oProbeValid)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_miss = 0, cyc = 0;
  int   fs_cnt = 0, probe_cnt = 0;
  int   last_x = 0, last_y = 0, fs_last_x = 0, fs_last_y = 0, first_x = -1, first_y = -1;
  int   drive_rise_cyc = 0, obs_rise_cyc = 0, rise_x = -1;
  logic fs_locked = 1'b0, locked_before_fs = 1'b0, locked_prev = 1'b0;
  logic pv_prev = 1'b0, want_first = 1'b0, prev_blank_drv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    if (x == PX && y == PY) return PROBE_RGB;
    return {8'(x), 8'(y), 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (oFrameStart) begin
      fs_cnt++;
      fs_locked        = oLocked;
      locked_before_fs = locked_prev;
      fs_last_x        = last_x;
      fs_last_y        = last_y;
      want_first       = 1'b1;
    end
    if (oPixelValid) begin
      if (want_first) begin
        first_x    = int'(oX);
        first_y    = int'(oY);
        want_first = 1'b0;
      end
      if (!pv_prev) begin
        obs_rise_cyc = cyc;
        rise_x       = int'(oX);
      end
      last_x = int'(oX);
      last_y = int'(oY);
    end
    if (oProbeValid) probe_cnt++;
    pv_prev     = oPixelValid;
    locked_prev = oLocked;
  endtask

  task automatic drive_lines(input int l0, input int l1, input int narrow);
    for (int l = l0; l <= l1; l++) begin
      for (int c = 0; c < HT; c++) begin
        logic bl;
        bl = (l < AH) && (c < ((l == narrow) ? AW - 1 : AW));
        if (bl && !prev_blank_drv) drive_rise_cyc = cyc;
        prev_blank_drv = bl;
        iBLANK_n = bl;
        iHS      = !(c >= HS_BEG && c < HS_END);
        iVS      = !(l >= VS_BEG && l < VS_END);
        iRGB     = bl ? pix(c, l) : 24'h0;
        tick();
      end
    end
  endtask

  task automatic hold_idle(input int n);
    iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iRGB = 24'h0;
    prev_blank_drv = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    iRST_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iRGB = 24'h0;
    iProbeX = 10'(PX); iProbeY = 10'(PY);
    repeat (3) tick();
    chk("rst_locked", oLocked, 0);
    chk("rst_errcnt", oErrCount, 0);
    chk("rst_linelen", oLineLen, 0);
    chk("rst_framelines", oFrameLines, 0);
    chk("rst_pixvalid", oPixelValid, 0);
    chk("rst_framestart", oFrameStart, 0);
    iRST_n = 1'b1;
    hold_idle(4);

    drive_lines(0, VT - 1, -1);
    chk("f1_fs_count", fs_cnt, 1);
    chk("f1_unlocked", oLocked, 0);
    chk("f1_search_exit_no_meas", oFrameLines, 0);

    drive_lines(0, VT - 1, -1);
    chk("f2_linelen", oLineLen, HT);
    chk("f2_activew", oActiveW, AW);
    chk("f2_activeh", oActiveH, AH);
    chk("f2_framelines", oFrameLines, VT);
    chk("f2_unlocked", oLocked, 0);

    drive_lines(0, VT - 1, -1);
    chk("f3_locked_at_fs", fs_locked, 1);
    chk("f3_unlocked_before_fs", locked_before_fs, 0);
    chk("pixel_latency", obs_rise_cyc - drive_rise_cyc, 3);
    chk("line_first_x", rise_x, 0);

    probe_cnt = 0;
    drive_lines(0, VT - 1, -1);
    chk("probe_pulses", probe_cnt, 1);
    chk("probe_rgb", oProbeRGB, PROBE_RGB);
    chk("last_pix_x", fs_last_x, AW - 1);
    chk("last_pix_y", fs_last_y, AH - 1);
    chk("f4_locked", oLocked, 1);

    drive_lines(0, VT - 1, -1);
    chk("first_pix_x", first_x, 0);
    chk("first_pix_y", first_y, 0);

    drive_lines(0, VT - 1, 5);
    chk("narrow_unlocked_at_fs", fs_locked, 0);
    chk("narrow_errcnt", oErrCount, 1);
    drive_lines(0, VT - 1, -1);
    chk("relock_1_unlocked", oLocked, 0);
    drive_lines(0, VT - 1, -1);
    chk("relock_2_locked", oLocked, 1);
    chk("relock_errcnt", oErrCount, 1);

    hold_idle(TO + 10);
    chk("timeout_unlocked", oLocked, 0);
    chk("timeout_errcnt", oErrCount, 1);
    drive_lines(0, VT - 1, -1);
    chk("to_search_exit", oLocked, 0);
    drive_lines(0, VT - 1, -1);
    chk("to_track_1", oLocked, 0);
    drive_lines(0, VT - 1, -1);
    chk("to_relocked", oLocked, 1);

    drive_lines(0, 6, -1);
    iRST_n = 1'b0;
    tick();
    chk("midrst_locked", oLocked, 0);
    chk("midrst_errcnt", oErrCount, 0);
    chk("midrst_linelen", oLineLen, 0);
    chk("midrst_activew", oActiveW, 0);
    chk("midrst_activeh", oActiveH, 0);
    chk("midrst_framelines", oFrameLines, 0);
    chk("midrst_probergb", oProbeRGB, 0);
    iRST_n = 1'b1;
    drive_lines(7, VT - 1, -1);
    chk("midrst_vs_no_framelines", oFrameLines, 0);
    chk("midrst_vs_no_activeh", oActiveH, 0);
    chk("midrst_vs_unlocked", oLocked, 0);
    chk("midrst_linelen_back", oLineLen, HT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Sink-side counterpart to the VGA output path: it consumes a VGA stream (HS, VS, BLANK_n, 24-bit RGB), recovers pixel coordinates, measures line and frame timing, and decides whether the stream is locked to the expected mode. It also captures one probe pixel per frame. It sits on the board-level loopback and self-test path, where it checks the renderer's output in hardware, and it is the front end for any future video-in capture.

## Interface
- EXP_ACTIVE_W, 640, required active pixels per line
- EXP_ACTIVE_H, 480, required active lines per frame
- LOCK_FRAMES, 2, consecutive good frames needed to assert lock (1..15)
- TIMEOUT, 4096, clocks without an HS falling edge before dropping to SEARCH

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge
- iRST_n  in  1  reset, synchronous, active-low
- iHS, iVS  in  1 each  sync inputs, active-low pulses
- iBLANK_n  in  1  high during active video
- iRGB  in  24  pixel data {R[23:16], G[15:8], B[7:0]}
- iProbeX, iProbeY  in  10 each  probe coordinate
- oPixelValid  out  1  active pixel on oRGB/oX/oY
- oX, oY  out  10 each  coordinate of current pixel
- oRGB  out  24  pixel data aligned with oPixelValid
- oFrameStart  out  1  one-cycle pulse on each VS falling edge
- oLineLen  out  11  clocks between the last two HS falling edges
- oActiveW  out  11  BLANK_n-high clocks in the last active segment
- oActiveH  out  10  active lines in the last completed frame
- oFrameLines  out  11  HS falling edges in the last completed frame
- oLocked  out  1  state == LOCKED
- oErrCount  out  8  count of LOCKED-to-TRACK drops, saturating at 255
- oProbeRGB  out  24  RGB captured at (iProbeX, iProbeY)
- oProbeValid  out  1  one-cycle pulse when oProbeRGB updates

## Operation
- Input stage: iHS/iVS/iBLANK_n/iRGB registered twice (s1, s2). An edge is detected when s1 differs from s2.
- Horizontal counter hcnt (11b, saturates at 2047):
  - Cleared to 0 on the HS-fall cycle; increments on every other cycle.
  - At each HS fall, oLineLen <= hcnt+1. The first fall after reset loads nothing.
- x counter:
  - Cleared to 0 on the BLANK_n-rise cycle; increments while s1 BLANK_n is high.
  - On BLANK_n fall, oActiveW <= segment length.
  - If that length differs from EXP_ACTIVE_W, set frame_bad.
- y counter:
  - VS fall sets first_line.
  - BLANK_n rise: if first_line, y <= 0 and clear first_line; otherwise y <= y+1.
  - active_lines counts BLANK_n rises in the frame.
- Frame end (VS fall):
  - oActiveH <= active_lines; oFrameLines <= HS-fall count since the previous VS fall.
  - Evaluate good = !frame_bad && active_lines == EXP_ACTIVE_H, then clear frame_bad, active_lines and the line count.
- State machine, 2-bit:
  - SEARCH: first VS fall -> TRACK, good_cnt=0. No evaluation is made for the partial frame.
  - TRACK: at VS fall, if good then good_cnt++; when good_cnt reaches LOCK_FRAMES -> LOCKED. If not good, good_cnt=0.
  - LOCKED: a bad frame -> TRACK, good_cnt=0, oErrCount++ (saturating).
  - Any state: TIMEOUT clocks since the last HS fall -> SEARCH, good_cnt=0. oErrCount is unchanged.
- Probe:
  - Capture occurs on the cycle with s1 BLANK_n high and x == iProbeX and y == iProbeY.
  - On that cycle, oProbeRGB <= s1 RGB and oProbeValid pulses.
  - iProbeX/iProbeY are sampled at VS fall and held for the frame.
- Simultaneous events: an HS fall and VS fall on the same cycle are both processed, and that HS fall counts toward the new frame. A VS fall in the same cycle as a timeout: the timeout wins, giving SEARCH.

## Timing
- Reset: all outputs 0, state SEARCH, all counters and flags 0. A reset applied mid-frame takes effect on the next rising edge and discards partial measurements.
- Pixel path latency:
  - Input sampled at edge n; oPixelValid/oX/oY/oRGB are valid after edge n+2.
  - First active pixel of a line shows oX=0.
- oFrameStart, oProbeValid and measurement updates are asserted after edge n+2 relative to the input edge that caused them.
- oLocked changes on the same cycle as the qualifying oFrameStart.

## Test plan
- Lock on standard mode: 640x480 timing (800 clocks/line, 525 lines/frame) from reset.
  - oLineLen=800, oActiveW=640, oActiveH=480, oFrameLines=525.
  - oLocked rises at the 3rd VS fall: the 1st fall leaves SEARCH, and the 2nd and 3rd are good frames.
- Coordinates: with the stream locked, the last active pixel shows oX=639, oY=479. The first pixel after the next VS shows oX=0, oY=0.
- Probe: iProbeX=100, iProbeY=200, source pixel there = 24'h123456 -> oProbeValid pulses once per frame, oProbeRGB=24'h123456.
- Line width error: once locked, make one line 639 wide -> at that frame's VS fall oLocked=0, oErrCount=1. Lock returns after 2 further good frames.
- Timeout: once locked, hold iHS high for 4096 clocks -> state SEARCH, oLocked=0, oErrCount unchanged.
- Reset mid-frame: pull iRST_n low for 1 cycle at line 240 -> all outputs 0 next cycle. oFrameLines is not updated at the next VS fall, which is a SEARCH exit only.
